// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver and transmitter).
//   UART_CLKS_PER_BIT : default sclk cycles per serial bit
//   rx_state_t        : receiver frame-tracking states
//   even_parity()     : parity bit that makes the total count of ones even
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 5209;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset to 1, which is the idle level of a UART line.
// Ports:
//   sclk  : clock, rising edge
//   reset : synchronous, active-low reset
//   d     : asynchronous input
//   q     : synchronized output (2-cycle latency)
// ---------------------------------------------------------------------------
module uart_sync (
  input  logic sclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sclk) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: 8 data bits LSB first, one stop bit, optional even parity.
// The line is sampled near the middle of every bit by a down-counter that is
// started half a bit period after the falling edge of the start bit.
//
// Parameters:
//   CLKS_PER_BIT : sclk cycles per serial bit (minimum 8)
// Ports:
//   sclk       : clock, rising edge
//   reset      : synchronous, active-low reset
//   rxd        : asynchronous serial line, idles high
//   data       : last received byte
//   valid      : data holds an unread byte
//   rd         : consumer acknowledge, clears valid
//   busy       : frame reception in progress
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : one-cycle pulse when a completed byte is dropped
//   parity_err : one-cycle pulse on a parity mismatch
// Build option:
//   UART_RX_PARITY_EN : adds an even-parity bit between data and stop (8E1);
//                       when undefined the frame is 8N1 and parity_err is 0.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       rd,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int               CTR_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CTR_W-1:0] CNT_FULL = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [CTR_W-1:0] CNT_HALF = CTR_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [CTR_W-1:0] cnt;
  logic [CTR_W-1:0] cnt_next;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;

  logic             rx_s;
  logic             rx_prev;
  logic [2:0]       arm_sr;
  logic             start_edge;

  logic             byte_done;
  logic             stop_bad;

`ifdef UART_RX_PARITY_EN
  logic             par_bit;
  logic             par_bit_next;
  logic             par_bad;
`endif

  uart_sync u_sync (
    .sclk  (sclk),
    .reset (reset),
    .d     (rxd),
    .q     (rx_s)
  );

  // After reset the synchronizer and rx_prev hold a forced 1 rather than a
  // real line sample. arm_sr delays edge detection until rx_prev and rx_s
  // both carry genuine samples, so a line that is already low when reset
  // releases (a frame in progress) is not mistaken for a new start bit.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      rx_prev <= 1'b1;
      arm_sr  <= '0;
    end else begin
      rx_prev <= rx_s;
      arm_sr  <= {arm_sr[1:0], 1'b1};
    end
  end

  assign start_edge = arm_sr[2] & rx_prev & ~rx_s;

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge sclk) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sclk) begin
    if (!reset) begin
      par_bit <= 1'b0;
    end else begin
      par_bit <= par_bit_next;
    end
  end
`endif

  // Every non-idle state counts down to 0 and acts on that cycle; the
  // counter is reloaded with a full bit period so the next action again
  // lands mid-bit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit;
    par_bad      = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_next = ST_START;
          cnt_next   = CNT_HALF;
        end
      end

      ST_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_next = ST_DATA;
            cnt_next   = CNT_FULL;
            idx_next   = 3'd0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt - CTR_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt == '0) begin
          shift_next[idx] = rx_s;
          cnt_next        = CNT_FULL;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            idx_next = idx + 3'd1;
          end
        end else begin
          cnt_next = cnt - CTR_W'(1);
        end
      end

      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt == '0) begin
          par_bit_next = rx_s;
          cnt_next     = CNT_FULL;
          state_next   = ST_STOP;
        end else begin
          cnt_next = cnt - CTR_W'(1);
        end
`else
        state_next = ST_IDLE;
`endif
      end

      ST_STOP: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
          if (!rx_s) begin
            stop_bad = 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (par_bit != even_parity(shift)) begin
              par_bad = 1'b1;
            end else begin
              byte_done = 1'b1;
            end
`else
            byte_done = 1'b1;
`endif
          end
        end else begin
          cnt_next = cnt - CTR_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A completed byte is accepted when the holding register is empty or is
  // being read in the same cycle; otherwise it is dropped and overrun pulses.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!valid || rd) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sclk) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with CLKS_PER_BIT = 16. A frame-level model
// predicts, for each frame sent, when it finishes and what it does to
// data/valid/busy and the error pulses; a compare process checks the DUT
// against it on every falling edge. Literal checks after each scenario pin
// the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Latency bound from the start edge to valid: 2 + C*9.5 + 2 for 8N1,
  // plus one bit period when a parity bit is present.
  localparam int LAT_MAX = 4 + (C * 19) / 2 + ((NBITS == 10) ? C : 0);

  logic       sclk;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       rd;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .sclk       (sclk),
    .reset      (reset),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .rd         (rd),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame model. kind: 0 good byte, 1 bad stop, 2 parity mismatch, 3 glitch.
  // start = edge after which busy is first 1, done = edge at which the frame
  // resolves (busy drops, results appear).
  typedef struct {
    int         start;
    int         done;
    logic [7:0] b;
    int         kind;
  } rec_t;

  rec_t       recs[$];
  int         cyc = 0;
  bit         model_ready = 0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_busy  = 1'b0;
  logic       exp_fe    = 1'b0;
  logic       exp_ov    = 1'b0;
  logic       exp_pe    = 1'b0;

  always @(posedge sclk) begin
    bit done_now;
    done_now = 1'b0;
    cyc      = cyc + 1;
    exp_fe   = 1'b0;
    exp_ov   = 1'b0;
    exp_pe   = 1'b0;
    if (!reset) begin
      exp_valid   = 1'b0;
      exp_data    = 8'h00;
      recs.delete();
      model_ready = 1'b1;
    end else begin
      foreach (recs[i]) begin
        if (recs[i].done == cyc) begin
          case (recs[i].kind)
            0: begin
              done_now = 1'b1;
              if (!exp_valid || rd) begin
                exp_data  = recs[i].b;
                exp_valid = 1'b1;
              end else begin
                exp_ov = 1'b1;
              end
            end
            1:       exp_fe = 1'b1;
            2:       exp_pe = 1'b1;
            default: ;
          endcase
        end
      end
      if (!done_now && rd && exp_valid) exp_valid = 1'b0;
      while (recs.size() > 0 && recs[0].done <= cyc) void'(recs.pop_front());
    end
    exp_busy = 1'b0;
    foreach (recs[i]) begin
      if (recs[i].start <= cyc && cyc < recs[i].done) exp_busy = 1'b1;
    end
  end

  always @(negedge sclk) begin
    if (model_ready) begin
      checkOutput("valid", valid, exp_valid);
      checkOutput("data", data, exp_data);
      checkOutput("busy", busy, exp_busy);
      checkOutput("frame_err", frame_err, exp_fe);
      checkOutput("overrun", overrun, exp_ov);
      checkOutput("parity_err", parity_err, exp_pe);
    end
  end

  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;

  always @(negedge sclk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
  end

  initial begin
    repeat (20000) @(posedge sclk);
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // Sends one frame starting now; bad_par inverts the parity bit when the
  // parity build is enabled.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input logic bad_par);
    rec_t r;
    r.start = cyc + 3;
    r.done  = cyc + 3 + C / 2 + C * NBITS;
    r.b     = b;
    r.kind  = !stop_val ? 1 : (bad_par ? 2 : 0);
    recs.push_back(r);
    rxd = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(C);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ bad_par;
    wait_cycles(C);
`endif
    rxd = stop_val;
    wait_cycles(C);
  endtask

  task automatic applyGlitch(input int n);
    rec_t r;
    r.start = cyc + 3;
    r.done  = cyc + 3 + C / 2;
    r.b     = 8'h00;
    r.kind  = 3;
    recs.push_back(r);
    rxd = 1'b0;
    wait_cycles(n);
    rxd = 1'b1;
  endtask

  task automatic doRead();
    rd = 1'b1;
    wait_cycles(1);
    rd = 1'b0;
  endtask

  int fe0, ov0, pe0, t0, lat;
  bit seen;

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    rd    = 1'b0;
    wait_cycles(3);
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_valid", valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    reset = 1'b1;
    wait_cycles(10);

    // Good frame 0x55 and start-edge-to-valid latency
    $display("[TB] frame 0x55");
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    seen = 1'b0; lat = 0;
    fork
      applyStimulus(8'h55, 1'b1, 1'b0);
      begin
        t0 = cyc;
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge sclk);
          if (valid === 1'b1) begin
            seen = 1'b1;
            lat  = cyc - t0;
          end
        end
      end
    join
    checkOutput("lat_seen", seen, 1'b1);
    checkOutput("lat_bound", (lat <= LAT_MAX), 1'b1);
    checkOutput("f55_data", data, 8'h55);
    checkOutput("f55_valid", valid, 1'b1);
    checkOutput("f55_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
    doRead();
    wait_cycles(2);
    checkOutput("rd_clears", valid, 1'b0);

    // Back-to-back 0xA3, 0x0F with no read: second is an overrun
    $display("[TB] frames 0xA3 0x0F");
    ov0 = ov_cnt;
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    wait_cycles(5);
    checkOutput("ovr_data", data, 8'hA3);
    checkOutput("ovr_valid", valid, 1'b1);
    checkOutput("ovr_pulses", ov_cnt - ov0, 1);
    doRead();
    wait_cycles(2);

    // 0x81 with stop bit 0, line then held low
    $display("[TB] frame 0x81 bad stop");
    fe0 = fe_cnt;
    applyStimulus(8'h81, 1'b0, 1'b0);
    wait_cycles(3 * C);
    checkOutput("fe_pulses", fe_cnt - fe0, 1);
    checkOutput("fe_valid", valid, 1'b0);
    checkOutput("fe_low_busy", busy, 1'b0);
    checkOutput("fe_data", data, 8'hA3);
    rxd = 1'b1;
    wait_cycles(2 * C);

    // 4-cycle low glitch
    $display("[TB] glitch");
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    applyGlitch(4);
    wait_cycles(3 * C);
    checkOutput("gl_valid", valid, 1'b0);
    checkOutput("gl_busy", busy, 1'b0);
    checkOutput("gl_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

    // Reset during data bit 4 of 0xFF, then a clean 0x3C
    $display("[TB] reset mid-frame");
    fork
      applyStimulus(8'hFF, 1'b1, 1'b0);
      begin
        wait_cycles(85);
        reset = 1'b0;
        wait_cycles(1);
        checkOutput("mid_rst_data", data, 8'h00);
        checkOutput("mid_rst_valid", valid, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        wait_cycles(1);
        reset = 1'b1;
      end
    join
    wait_cycles(10);
    checkOutput("post_rst_valid", valid, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    wait_cycles(2);
    checkOutput("f3c_data", data, 8'h3C);
    checkOutput("f3c_valid", valid, 1'b1);
    doRead();
    wait_cycles(2);

`ifdef UART_RX_PARITY_EN
    $display("[TB] frame 0x07 bad parity");
    pe0 = pe_cnt; ov0 = ov_cnt;
    applyStimulus(8'h07, 1'b1, 1'b1);
    wait_cycles(4);
    checkOutput("pe_pulses", pe_cnt - pe0, 1);
    checkOutput("pe_valid", valid, 1'b0);
    checkOutput("pe_no_ovr", ov_cnt - ov0, 0);
`endif

    wait_cycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5209: sclk cycles per serial bit (minimum 8).
REQ-002 SHALL have port sclk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rxd  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port data  output  8  last received byte.
REQ-006 SHALL have port valid  output  1  data holds an unread byte.
REQ-007 SHALL have port rd  input  1  consumer acknowledge; clears valid.
REQ-008 SHALL have port busy  output  1  frame reception in progress.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-013 SHALL implement states IDLE, START, DATA, (PARITY), STOP; busy = 1 in every state except IDLE.
REQ-014 IDLE: SHALL enter START only on a 1->0 transition of rx_s; a line held low never re-arms. On entry, bit counter = CLKS_PER_BIT/2 - 1 (integer division).
REQ-015 START: at counter 0, rx_s = 0 -> DATA with counter = CLKS_PER_BIT-1 and bit index 0; rx_s = 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: at counter 0, SHALL sample rx_s into shift bit [index], LSB first, and reload counter; after index 7 -> STOP (or PARITY).
REQ-017 STOP: at counter 0, rx_s = 1 -> byte complete, go IDLE; rx_s = 0 -> frame_err pulse, byte discarded, go IDLE.
REQ-018 On byte complete with valid = 0 or rd = 1 that cycle: data <= byte, valid <= 1 on the next edge.
REQ-019 On byte complete with valid = 1 and rd = 0: byte dropped, data unchanged, overrun pulses one cycle.
REQ-020 rd with valid = 1 and no simultaneous completion: valid <= 0 next edge; rd with valid = 0 SHALL be ignored.
REQ-021 Counter SHALL be $clog2(CLKS_PER_BIT) bits wide and decrement by 1 per cycle, never wrap below 0.

Reset
REQ-022 reset = 0 SHALL force IDLE, data = 8'h00, valid = 0, busy = 0, all flags 0, synchronizer flops = 1, at any point including mid-frame; the partial byte is lost.
REQ-023 After reset release, a frame already in progress SHALL NOT be received unless a fresh 1->0 edge is seen.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples one even-parity bit; mismatch -> parity_err pulse at the end of STOP, byte discarded (no valid, no overrun).
REQ-025 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is 8N1, parity_err tied 0.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum, the default CLKS_PER_BIT constant (shared with the transmitter) and the parity-bit helper function.
REQ-027 Sub-module uart_sync (2-flop synchronizer, reset value 1) SHALL be instantiated for rxd.

Verification (bench uses CLKS_PER_BIT = 16)
REQ-028 Frame 0x55, good stop -> valid rises within 2 + 16*9.5 + 2 cycles of the start edge, data = 0x55, flags 0.
REQ-029 Two back-to-back frames 0xA3, 0x0F, rd never asserted -> data = 0xA3, overrun pulses once, valid stays 1.
REQ-030 Frame 0x81 with stop bit 0 -> frame_err one pulse, valid stays 0; rxd held low afterwards -> no further frames, busy = 0.
REQ-031 rxd low pulse of 4 cycles -> returns to IDLE after START, no valid, no flags.
REQ-032 reset asserted at DATA bit 4 of frame 0xFF -> all outputs at reset values next cycle; the next clean frame 0x3C is received correctly.
REQ-033 With UART_RX_PARITY_EN, frame 0x07 sent with parity 0 (should be 1) -> parity_err one pulse, valid stays 0.
